// File: rtl/spi_cv_pkg.sv
// Shared types and helpers for the CV SPI receiver: state encoding,
// default geometry and the word-to-bus offset mapping.
package spi_cv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECEIVE  = 2'd1,
        COMPLETE = 2'd2
    } state_e;

    localparam int DEF_CHANNELS     = 5;
    localparam int DEF_WORD_BITS    = 16;
    localparam int DEF_FILTER_COUNT = 3;

    function automatic int word_offset(input int idx, input int word_bits);
        return idx * word_bits;
    endfunction

endpackage

// File: rtl/spi_input_filter.sv
// Two-flop synchronisers on CS/SCK/DATA followed by a joint stability filter:
// the filtered triple only moves after FILTER_COUNT consecutive equal samples.
module spi_input_filter
    import spi_cv_pkg::*;
#(
    parameter int FILTER_COUNT = DEF_FILTER_COUNT
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Cs,
    input  logic i_Sck,
    input  logic i_Data,
    output logic o_Cs,
    output logic o_Sck,
    output logic o_Data,
    output logic o_Settled
);

    localparam int CW = $clog2(FILTER_COUNT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FILTER_COUNT - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_COUNT - 2);
    localparam logic [2:0]    IDLE_LINES = 3'b100;

    logic [2:0]    sync1_q, sync2_q, prev_q;
    logic [2:0]    filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    fill_q;
    logic          stable;

    always_comb begin
        stable = (sync2_q == prev_q);
        cnt_d  = '0;
        filt_d = filt_q;
        if (stable) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            if (cnt_q >= CNT_LOAD) begin
                filt_d = sync2_q;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync1_q <= IDLE_LINES;
            sync2_q <= IDLE_LINES;
            prev_q  <= IDLE_LINES;
            filt_q  <= IDLE_LINES;
            cnt_q   <= '0;
            fill_q  <= '0;
        end else begin
            sync1_q <= {i_Cs, i_Sck, i_Data};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            // Settled is withheld until the reset values have left the pipeline.
            fill_q  <= (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        end
    end

    assign o_Cs      = filt_q[2];
    assign o_Sck     = filt_q[1];
    assign o_Data    = filt_q[0];
    assign o_Settled = (fill_q == 2'd3) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/spi_cv_receiver.sv
// Oversampled 3-wire SPI frame receiver: filters the pins, assembles CHANNELS
// words into a staging buffer and commits them atomically on a clean frame end.
module spi_cv_receiver
    import spi_cv_pkg::*;
#(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int WORD_BITS    = DEF_WORD_BITS,
    parameter int FILTER_COUNT = DEF_FILTER_COUNT,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_SPI_CS,
    input  logic                          i_SPI_Clock,
    input  logic                          i_SPI_Data,
    output logic [CHANNELS*WORD_BITS-1:0] o_Data,
    output logic                          o_Data_Valid,
    output logic                          o_Frame_Error,
    output logic                          o_Busy
);

    localparam int BW = $clog2(WORD_BITS);
    localparam int WW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_BITS - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(CHANNELS - 1);

    logic f_cs, f_sck, f_data, f_settled;
    logic cs_prev_q, sck_prev_q, armed_q;
    logic sck_rise, cs_fall, cs_rise;

    state_e                 state_q, state_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]          word_cnt_q, word_cnt_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d, new_word;
    logic [WORD_BITS-1:0]   staging_q [CHANNELS];
    logic [WORD_BITS-1:0]   staging_d [CHANNELS];
    logic [WORD_BITS-1:0]   data_q [CHANNELS];
    logic [WORD_BITS-1:0]   data_d [CHANNELS];
    logic                   overrun_q, overrun_d;
    logic                   valid_q, valid_d, err_q, err_d;

    spi_input_filter #(.FILTER_COUNT(FILTER_COUNT)) u_filter (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Cs      (i_SPI_CS),
        .i_Sck     (i_SPI_Clock),
        .i_Data    (i_SPI_Data),
        .o_Cs      (f_cs),
        .o_Sck     (f_sck),
        .o_Data    (f_data),
        .o_Settled (f_settled)
    );

    assign sck_rise = f_sck & ~sck_prev_q;
    assign cs_fall  = ~f_cs & cs_prev_q;
    assign cs_rise  = f_cs & ~cs_prev_q;
    assign new_word = MSB_FIRST ? {shift_q[WORD_BITS-2:0], f_data}
                                : {f_data, shift_q[WORD_BITS-1:1]};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        staging_d  = staging_q;
        data_d     = data_q;
        overrun_d  = overrun_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d  = '0;
                word_cnt_d = '0;
                shift_d    = '0;
                overrun_d  = 1'b0;
                // A CS low left over from reset never counts as a frame start.
                if (cs_fall && armed_q) state_d = RECEIVE;
            end
            RECEIVE: begin
                if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sck_rise) begin
                    shift_d = new_word;
                    if (bit_cnt_q == LAST_BIT) begin
                        staging_d[word_cnt_q] = new_word;
                        bit_cnt_d = '0;
                        if (word_cnt_q == LAST_WORD) state_d = COMPLETE;
                        else word_cnt_d = word_cnt_q + WW'(1);
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            COMPLETE: begin
                if (cs_rise) begin
                    if (overrun_q) err_d = 1'b1;
                    else begin
                        data_d  = staging_q;
                        valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (sck_rise) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            shift_q    <= '0;
            staging_q  <= '{default: '0};
            data_q     <= '{default: '0};
            overrun_q  <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            staging_q  <= staging_d;
            data_q     <= data_d;
            overrun_q  <= overrun_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            cs_prev_q  <= f_cs;
            sck_prev_q <= f_sck;
            armed_q    <= armed_q | (f_settled & f_cs);
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_out
        assign o_Data[word_offset(n, WORD_BITS) +: WORD_BITS] = data_q[n];
    end

    assign o_Data_Valid  = valid_q;
    assign o_Frame_Error = err_q;
    assign o_Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cv_receiver.sv
// Directed bench for spi_cv_receiver: one MSB-first and one LSB-first instance
// share the SPI pins; committed frames are checked against an expected queue.
module tb_spi_cv_receiver;

    localparam int CH = 5;
    localparam int WB = 16;
    localparam int FC = 3;
    localparam int DW = CH * WB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs = 1'b1;
    logic sck = 1'b0;
    logic sdata = 1'b0;

    logic [DW-1:0] data_m, data_l;
    logic          valid_m, valid_l, err_m, err_l, busy_m, busy_l;

    always #5 clk = ~clk;

    spi_cv_receiver #(.CHANNELS(CH), .WORD_BITS(WB), .FILTER_COUNT(FC), .MSB_FIRST(1'b1)) dut_msb (
        .i_Clock(clk), .i_Reset(rst), .i_SPI_CS(cs), .i_SPI_Clock(sck), .i_SPI_Data(sdata),
        .o_Data(data_m), .o_Data_Valid(valid_m), .o_Frame_Error(err_m), .o_Busy(busy_m)
    );

    spi_cv_receiver #(.CHANNELS(CH), .WORD_BITS(WB), .FILTER_COUNT(FC), .MSB_FIRST(1'b0)) dut_lsb (
        .i_Clock(clk), .i_Reset(rst), .i_SPI_CS(cs), .i_SPI_Clock(sck), .i_SPI_Data(sdata),
        .o_Data(data_l), .o_Data_Valid(valid_l), .o_Frame_Error(err_l), .o_Busy(busy_l)
    );

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_l_q[$];
    logic [DW-1:0] last_m = '0;
    logic [DW-1:0] last_l = '0;
    int checks = 0;
    int errors = 0;
    int n_valid_m = 0, n_valid_l = 0, n_err_m = 0, n_err_l = 0;
    int exp_valid = 0, exp_err = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (valid_m) begin
            n_valid_m++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid_msb: observed=%h expected=none", data_m);
            end
            if (exp_q.size() != 0) begin
                last_m = exp_q.pop_front();
                check("commit_msb", data_m, last_m);
            end
        end else if (!rst) begin
            check("hold_msb", data_m, last_m);
        end
        if (valid_l) begin
            n_valid_l++;
            checks++;
            assert (exp_l_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid_lsb: observed=%h expected=none", data_l);
            end
            if (exp_l_q.size() != 0) begin
                last_l = exp_l_q.pop_front();
                check("commit_lsb", data_l, last_l);
            end
        end else if (!rst) begin
            check("hold_lsb", data_l, last_l);
        end
        if (err_m) n_err_m++;
        if (err_l) n_err_l++;
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        sck = 1'b0;
        sdata = b;
        cycles(6);
        if (glitch) begin
            sck = 1'b1; cycles(1); sck = 1'b0; cycles(5);
        end else cycles(6);
        sck = 1'b1;
        cycles(6);
        if (glitch) begin
            sdata = ~b; cycles(1); sdata = b; cycles(5);
        end else cycles(6);
    endtask

    task automatic send_word(input logic [WB-1:0] w, input bit glitch);
        for (int i = WB - 1; i >= 0; i--) send_bit(w[i], glitch);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        cycles(12);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        cycles(12);
    endtask

    function automatic logic [WB-1:0] rev_word(input logic [WB-1:0] w);
        logic [WB-1:0] r;
        for (int i = 0; i < WB; i++) r[i] = w[WB-1-i];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_frame();
        logic [DW-1:0] f;
        for (int n = 0; n < CH; n++) f[n*WB +: WB] = WB'($urandom_range(0, 65535));
        return f;
    endfunction

    task automatic send_frame(input logic [DW-1:0] f, input bit glitch);
        for (int n = 0; n < CH; n++) send_word(f[n*WB +: WB], glitch);
    endtask

    task automatic push_expect(input logic [DW-1:0] f);
        logic [DW-1:0] lf;
        for (int n = 0; n < CH; n++) lf[n*WB +: WB] = rev_word(f[n*WB +: WB]);
        exp_q.push_back(f);
        exp_l_q.push_back(lf);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_valid_msb"}, DW'(n_valid_m), DW'(exp_valid));
        check({tag, "_valid_lsb"}, DW'(n_valid_l), DW'(exp_valid));
        check({tag, "_err_msb"}, DW'(n_err_m), DW'(exp_err));
        check({tag, "_err_lsb"}, DW'(n_err_l), DW'(exp_err));
    endtask

    // ---------------- directed sequence ----------------
    logic [DW-1:0] fa, fb, fc, fd, fe;
    logic [WB-1:0] w0;

    initial begin
        fa = {16'hFFFF, 16'h8000, 16'h0001, 16'hABCD, 16'h1234};
        fb = {16'h7E81, 16'h0F0F, 16'hC3C3, 16'h5A5A, 16'h8000};
        fc = rand_frame();
        fd = rand_frame();
        fe = rand_frame();

        cycles(4);
        check("reset_data", data_m, '0);
        check("reset_valid", DW'(valid_m), '0);
        check("reset_err", DW'(err_m), '0);
        check("reset_busy", DW'(busy_m), '0);
        rst = 1'b0;
        cycles(20);

        // clean MSB-first frame
        cs_low();
        check("busy_in_frame", DW'(busy_m), DW'(1'b1));
        send_frame(fa, 1'b0);
        push_expect(fa);
        cs_high();
        exp_valid++;
        check_counts("frame_a");
        check("frame_a_data", data_m, fa);
        check("frame_a_busy", DW'(busy_m), '0);

        // glitches on SCK and DATA; word 0 sent as 1,0,0,...
        cs_low();
        send_frame(fb, 1'b1);
        push_expect(fb);
        cs_high();
        exp_valid++;
        check_counts("frame_b");
        w0 = data_m[WB-1:0];
        check("msb_first_word0", DW'(w0), DW'(16'h8000));
        w0 = data_l[WB-1:0];
        check("lsb_first_word0", DW'(w0), DW'(16'h0001));

        // short frame: 3 words + 5 bits
        cs_low();
        for (int n = 0; n < 3; n++) send_word(fc[n*WB +: WB], 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        cs_high();
        exp_err++;
        check_counts("short");
        check("short_data_kept", data_m, fb);
        check("short_busy", DW'(busy_m), '0);

        // next clean frame after the short one
        cs_low();
        send_frame(fc, 1'b0);
        push_expect(fc);
        cs_high();
        exp_valid++;
        check_counts("frame_c");
        check("frame_c_data", data_m, fc);

        // overrun: two extra SCK pulses after the last bit
        cs_low();
        send_frame(fd, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        cs_high();
        exp_err++;
        check_counts("overrun");
        check("overrun_data_kept", data_m, fc);

        // reset in the middle of word 2 with CS held low
        cs_low();
        for (int n = 0; n < 2; n++) send_word(fd[n*WB +: WB], 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        last_m = '0;
        last_l = '0;
        cycles(3);
        check("midreset_data", data_m, '0);
        check("midreset_busy", DW'(busy_m), '0);
        rst = 1'b0;
        cycles(20);
        check("cs_low_at_release_busy", DW'(busy_m), '0);
        send_word(16'hDEAD, 1'b0);
        check("no_frame_busy", DW'(busy_m), '0);
        cs_high();
        check_counts("after_reset");
        check("after_reset_data", data_m, '0);

        // fresh frame after reset commits normally
        cs_low();
        send_frame(fe, 1'b0);
        push_expect(fe);
        cs_high();
        exp_valid++;
        check_counts("frame_e");
        check("frame_e_data", data_m, fe);

        cycles(10);
        check("queue_empty_msb", DW'(exp_q.size()), '0);
        check("queue_empty_lsb", DW'(exp_l_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
